fetch_queue_unit: RTL
=====================

# fetch_queue_unit

Parametrised front-end successor to the single-register instruction unit: fetches from the icache, predecodes control flow to compute the next PC, and buffers instructions in a DEPTH-entry queue that feeds the issue stage over a valid/ready handshake. It sits between the icache and predictor on one side and the issue/dispatch logic (RS, LSB, ROB) on the other. It resolves JALR by stalling fetch until the ROB returns the target, and it accepts a full pipeline flush/redirect from the ROB.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- ROB_WIDTH, 4: ROB tag width.
- RESET_PC, 32'h0: PC after reset.

Ports:
- clockIn  in  1  clock, rising edge.
- resetIn  in  1  asynchronous, active-high reset.
- instrInValid  in  1  icache data valid.
- instrIn  in  32  icache instruction word.
- instrAddr  in  32  address of instrIn.
- jump  in  1  predictor taken bit for the branch currently on instrIn.
- fetchValid  out  1  fetch request to icache.
- fetchAddr  out  32  current PC.
- robNext  in  ROB_WIDTH  next free ROB tag.
- robReady  in  1  requested ROB entry has its value.
- robValue  in  32  value of the requested entry (JALR target).
- robRequest  out  ROB_WIDTH  tag of the pending JALR.
- flush  in  1  mispredict/exception redirect.
- flushAddr  in  32  redirect PC.
- issueValid  out  1  queue head valid.
- issueInstr  out  32  head instruction.
- issueAddr  out  32  head PC.
- issueJump  out  1  predicted-taken bit of the head.
- issueReady  in  1  downstream accepts the head.
- queueCount  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- States: FETCH, STALL.
- fetchValid = (state == FETCH) && (count < DEPTH). fetchAddr = PC.
- Accept: fetchValid && instrInValid && instrAddr == PC. A mismatched address is dropped silently.
- On accept, enqueue {instrIn, PC, jump-if-branch}. The next PC depends on opcode:
  - branch 1100011: jump ? PC+B-imm : PC+4.
  - JAL 1101111: PC+J-imm.
  - JALR 1100111: PC held; go to STALL; robRequest <= robNext + count (mod 2^ROB_WIDTH). This is the tag the JALR receives, with count taken before this enqueue.
  - others: PC+4.
- STALL: when robReady, PC <= robValue & ~32'h1, then return to FETCH. robRequest holds its value until the next JALR.
- Dequeue when issueValid && issueReady. Enqueue and dequeue may occur in the same cycle, and count is updated accordingly.
- issueJump is 0 for non-branches.
- flush has highest priority:
  - queue emptied (count 0, pointers 0), PC <= flushAddr, state FETCH.
  - any fetch or dequeue in that cycle is void; downstream flushes in the same cycle.
- Arithmetic: PC arithmetic is 32-bit wrapping. Immediates are sign-extended from instruction bit 31. Queue pointers wrap modulo DEPTH.

## Timing
- Reset values (asynchronous): PC = RESET_PC, state FETCH, count 0, robRequest 0, issueValid 0.
  - Consequently fetchValid = 1 and fetchAddr = RESET_PC immediately after reset.
- Accepted instruction appears at issue the next cycle. Fetch-to-issue latency is 1 cycle when the queue is empty.
- Queue full: fetchValid = 0. A dequeue in the same cycle does not admit a new fetch; fetchValid reasserts the following cycle.
- New PC is visible on fetchAddr one cycle after accept, flush, or robReady.
- JALR: fetchValid drops the cycle after accept and stays 0 until the cycle after robReady.
- Simultaneous flush and robReady: flush wins; PC = flushAddr.
- Reset mid-STALL or with a non-empty queue returns to the reset values immediately.

## Structure
- Shared package fetch_pkg:
  - opcode constants: OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM.
  - immediate-extraction functions: imm_b, imm_j, imm_i.
  - queue entry struct.
- One sub-module, instr_queue_fifo:
  - parametrised circular buffer with head/tail pointers, count, push/pop/clear.
  - head registered output.
- PC/state logic stays in the top.

## Test plan
- Reset, then 3 ALU instructions at 0x0, 0x4, 0x8 with issueReady=1 -> issue in order one cycle after each accept; fetchAddr reaches 0xC.
- issueReady=0, DEPTH=4, fetch 5 -> count=4, fetchValid=0, 5th not accepted. Raise issueReady -> drain in order, fetch resumes at 0x10.
- Branch at 0x10 with B-imm=-8 and jump=1 -> next fetchAddr 0x8, issueJump=1. Same branch with jump=0 -> next fetchAddr 0x14.
- JALR with count=2 and robNext=4'hF -> robRequest=4'h1, fetchValid=0. robReady with robValue=0x105 -> fetchAddr 0x104 the next cycle.
- flush with flushAddr=0x200 while the queue holds 3 entries and state is STALL -> count 0, issueValid 0, fetchAddr 0x200, state FETCH. Also assert flush in the same cycle as robReady -> flushAddr wins.
- icache returns instrAddr != PC -> no enqueue, PC unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: opcode constants, immediate
// decoding helpers, FSM states and the instruction-queue entry layout.
package fetch_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      STALL = 1'b1
   } fetchState_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        jump;
   } fetchEntry_t;

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{21{instr[31]}}, instr[30:20]};
   endfunction

endpackage

// File: rtl/instr_queue_fifo.sv
// Circular instruction buffer: head/tail pointers wrap modulo DEPTH and the
// head entry is read straight out of the storage registers.
module instr_queue_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clockIn,
   input  logic                     resetIn,
   input  logic                     push,
   input  fetchEntry_t              pushData,
   input  logic                     pop,
   input  logic                     clear,
   output logic                     headValid,
   output fetchEntry_t              headData,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetchEntry_t   memR [DEPTH];
   logic [PW-1:0] headR;
   logic [PW-1:0] tailR;
   logic [CW-1:0] countR;

   // pointer and occupancy bookkeeping; clear wins over push/pop
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         headR  <= '0;
         tailR  <= '0;
         countR <= '0;
      end else if (clear) begin
         headR  <= '0;
         tailR  <= '0;
         countR <= '0;
      end else begin
         if (push) begin
            tailR <= tailR + PW'(1);
         end
         if (pop) begin
            headR <= headR + PW'(1);
         end
         countR <= countR + CW'(push) - CW'(pop);
      end
   end

   // entry storage
   always_ff @(posedge clockIn) begin
      if (push && !clear) begin
         memR[tailR] <= pushData;
      end
   end

   assign headValid = (countR != '0);
   assign headData  = memR[headR];
   assign count     = countR;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC sequencing with control-flow predecode,
// JALR resolution through the ROB, and a DEPTH-entry issue queue.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int          ROB_WIDTH = 4,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic                      clockIn,
   input  logic                      resetIn,
   input  logic                      instrInValid,
   input  logic [31:0]               instrIn,
   input  logic [31:0]               instrAddr,
   input  logic                      jump,
   output logic                      fetchValid,
   output logic [31:0]               fetchAddr,
   input  logic [ROB_WIDTH-1:0]      robNext,
   input  logic                      robReady,
   input  logic [31:0]               robValue,
   output logic [ROB_WIDTH-1:0]      robRequest,
   input  logic                      flush,
   input  logic [31:0]               flushAddr,
   output logic                      issueValid,
   output logic [31:0]               issueInstr,
   output logic [31:0]               issueAddr,
   output logic                      issueJump,
   input  logic                      issueReady,
   output logic [$clog2(DEPTH):0]    queueCount
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetchState_t          stateR;
   fetchState_t          stateNextS;
   logic [31:0]          pcR;
   logic [31:0]          pcNextS;
   logic [ROB_WIDTH-1:0] robRequestR;
   logic [6:0]           opcodeS;
   logic                 isJalrS;
   logic                 acceptS;
   logic                 popS;
   logic                 headValidS;
   logic [CW-1:0]        countS;
   fetchEntry_t          pushEntryS;
   fetchEntry_t          headEntryS;

   assign opcodeS    = instrIn[6:0];
   assign isJalrS    = (opcodeS == OPC_JALR);
   assign acceptS    = fetchValid && instrInValid && (instrAddr == pcR) && !flush;
   assign popS       = headValidS && issueReady && !flush;
   assign pushEntryS = '{instr: instrIn, addr: pcR, jump: (opcodeS == OPC_BRANCH) && jump};

   instr_queue_fifo #(
      .DEPTH(DEPTH)
   ) queue (
      .clockIn   (clockIn),
      .resetIn   (resetIn),
      .push      (acceptS),
      .pushData  (pushEntryS),
      .pop       (popS),
      .clear     (flush),
      .headValid (headValidS),
      .headData  (headEntryS),
      .count     (countS)
   );

   // state register
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         stateR <= FETCH;
      end else begin
         stateR <= stateNextS;
      end
   end

   // next state: a JALR parks fetch until the ROB supplies the target
   always_comb begin
      stateNextS = stateR;
      if (flush) begin
         stateNextS = FETCH;
      end else begin
         case (stateR)
            FETCH:   stateNextS = (acceptS && isJalrS) ? STALL : FETCH;
            STALL:   stateNextS = robReady ? FETCH : STALL;
            default: stateNextS = FETCH;
         endcase
      end
   end

   // state-decoded outputs
   always_comb begin
      fetchValid = 1'b0;
      case (stateR)
         FETCH:   fetchValid = (countS < CW'(DEPTH));
         STALL:   fetchValid = 1'b0;
         default: fetchValid = 1'b0;
      endcase
   end

   // next PC from predecode, ROB return or redirect
   always_comb begin
      pcNextS = pcR;
      if (flush) begin
         pcNextS = flushAddr;
      end else if (stateR == STALL) begin
         if (robReady) begin
            pcNextS = robValue & ~32'h1;
         end else begin
            pcNextS = pcR;
         end
      end else if (acceptS) begin
         case (opcodeS)
            OPC_BRANCH: pcNextS = jump ? (pcR + imm_b(instrIn)) : (pcR + 32'd4);
            OPC_JAL:    pcNextS = pcR + imm_j(instrIn);
            OPC_JALR:   pcNextS = pcR;
            default:    pcNextS = pcR + 32'd4;
         endcase
      end else begin
         pcNextS = pcR;
      end
   end

   // PC register
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         pcR <= RESET_PC;
      end else begin
         pcR <= pcNextS;
      end
   end

   // the JALR's own ROB tag is the next free tag offset by what is still queued ahead of it
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         robRequestR <= '0;
      end else if (acceptS && isJalrS) begin
         robRequestR <= robNext + ROB_WIDTH'(countS);
      end
   end

   assign fetchAddr  = pcR;
   assign robRequest = robRequestR;
   assign issueValid = headValidS;
   assign issueInstr = headEntryS.instr;
   assign issueAddr  = headEntryS.addr;
   assign issueJump  = headEntryS.jump;
   assign queueCount = countS;

endmodule
